write_back_unit: RTL and testbench

- Registered, parametrised write-back stage for the RV64 pipeline: captures the MEM/WB bundle, selects the register-file result from NUM_SRC sources and drives the register-file write port one cycle later.
- Adds retirement tracking and a halt state machine. On ecall it latches an exit status (a0 LSB, mcause) for the testbench to read, in place of stopping simulation directly.
- Sits between the memory stage and the register file / forwarding network.

---
 rtl/wb_pkg.sv | 17 +
 rtl/result_mux_n.sv | 22 ++
 rtl/write_back_unit.sv | 136 +++++++++++++
 tb/tb_write_back_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the write-back stage
package wb_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_PCT = 3;
    localparam int SRC_IMM = 4;

    localparam logic [7:0] ECALL_PASS_A0 = 8'h00;

endpackage

// File: rtl/result_mux_n.sv
// rtl/result_mux_n.sv - one-of-N result selector with zero default
module result_mux_n #(
    parameter int NUM_SRC    = 5,
    parameter int DATA_WIDTH = 64,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]              i_sel,
    output logic [DATA_WIDTH-1:0]         o_data
);

    // Out-of-range selects fall through every compare and keep the zero default.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(i_sel) == i) begin
                o_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - registered write-back stage with retire count and ecall halt
module write_back_unit
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 5,
    parameter int SEL_W      = $clog2(NUM_SRC),
    parameter int CNT_WIDTH  = 64
) (
    input  logic                          i_clk,
    input  logic                          i_arstn,
    input  logic                          i_valid,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
    input  logic [SEL_W-1:0]              i_result_src,
    input  logic [REG_ADDR_W-1:0]         i_rd_addr,
    input  logic                          i_reg_we,
    input  logic                          i_ecall_instr,
    input  logic [3:0]                    i_cause,
    input  logic [7:0]                    i_a0_reg_lsb,
    output logic [DATA_WIDTH-1:0]         o_result,
    output logic [REG_ADDR_W-1:0]         o_rd_addr,
    output logic                          o_reg_we,
    output logic                          o_retire,
    output logic [CNT_WIDTH-1:0]          o_instret,
    output logic                          o_accept,
    output logic                          o_halt,
    output logic [7:0]                    o_exit_a0,
    output logic [3:0]                    o_exit_cause
);

    // PC-derived sources are pre-widened into DATA_WIDTH lanes, so the PC must fit.
    if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
        $error("ADDR_WIDTH must not exceed DATA_WIDTH");
    end

    wb_state_t                     r_state;
    wb_state_t                     w_next_state;
    logic                          r_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] r_src_data;
    logic [SEL_W-1:0]              r_result_src;
    logic [REG_ADDR_W-1:0]         r_rd_addr;
    logic                          r_reg_we;
    logic                          r_ecall;
    logic [3:0]                    r_cause;
    logic [7:0]                    r_a0;
    logic [CNT_WIDTH-1:0]          r_instret;
    logic [7:0]                    r_exit_a0;
    logic [3:0]                    r_exit_cause;
    logic                          w_halt_req;

    assign w_halt_req = r_valid & r_ecall;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (w_halt_req) w_next_state = HALTED;
            HALTED:  w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
    end

    // The instruction captured alongside the retiring ecall is dropped here,
    // since upstream only sees o_accept fall one cycle later.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_valid      <= 1'b0;
            r_src_data   <= '0;
            r_result_src <= '0;
            r_rd_addr    <= '0;
            r_reg_we     <= 1'b0;
            r_ecall      <= 1'b0;
            r_cause      <= '0;
            r_a0         <= '0;
            r_instret    <= '0;
            r_exit_a0    <= '0;
            r_exit_cause <= '0;
        end else begin
            if ((r_state == HALTED) || w_halt_req || i_flush || i_stall) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= i_valid;
            end

            if (!i_stall && (r_state == RUN)) begin
                r_src_data   <= i_src_data;
                r_result_src <= i_result_src;
                r_rd_addr    <= i_rd_addr;
                r_reg_we     <= i_reg_we;
                r_ecall      <= i_ecall_instr;
                r_cause      <= i_cause;
                r_a0         <= i_a0_reg_lsb;
            end

            if (r_valid) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end

            if (w_halt_req) begin
                r_exit_a0    <= r_a0;
                r_exit_cause <= r_cause;
            end
        end
    end

    result_mux_n #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_W      (SEL_W)
    ) u_result_mux (
        .i_data (r_src_data),
        .i_sel  (r_result_src),
        .o_data (o_result)
    );

    assign o_rd_addr    = r_rd_addr;
    assign o_reg_we     = r_valid & r_reg_we & (r_rd_addr != '0) & ~r_ecall;
    assign o_retire     = r_valid;
    assign o_instret    = r_instret;
    assign o_accept     = (r_state == RUN);
    assign o_halt       = (r_state == HALTED);
    assign o_exit_a0    = r_exit_a0;
    assign o_exit_cause = r_exit_cause;

endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - directed self-checking bench for write_back_unit
module tb_write_back_unit;
    import wb_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_arstn;
    logic         i_valid;
    logic         i_stall;
    logic         i_flush;
    logic [319:0] i_src_data;
    logic [2:0]   i_result_src;
    logic [4:0]   i_rd_addr;
    logic         i_reg_we;
    logic         i_ecall_instr;
    logic [3:0]   i_cause;
    logic [7:0]   i_a0_reg_lsb;
    logic [63:0]  o_result;
    logic [4:0]   o_rd_addr;
    logic         o_reg_we;
    logic         o_retire;
    logic [63:0]  o_instret;
    logic         o_accept;
    logic         o_halt;
    logic [7:0]   o_exit_a0;
    logic [3:0]   o_exit_cause;

    int checks = 0;
    int errors = 0;

    logic [63:0] lane [5];

    write_back_unit dut (
        .i_clk         (i_clk),
        .i_arstn       (i_arstn),
        .i_valid       (i_valid),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_src_data    (i_src_data),
        .i_result_src  (i_result_src),
        .i_rd_addr     (i_rd_addr),
        .i_reg_we      (i_reg_we),
        .i_ecall_instr (i_ecall_instr),
        .i_cause       (i_cause),
        .i_a0_reg_lsb  (i_a0_reg_lsb),
        .o_result      (o_result),
        .o_rd_addr     (o_rd_addr),
        .o_reg_we      (o_reg_we),
        .o_retire      (o_retire),
        .o_instret     (o_instret),
        .o_accept      (o_accept),
        .o_halt        (o_halt),
        .o_exit_a0     (o_exit_a0),
        .o_exit_cause  (o_exit_cause)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_lanes(input logic [63:0] alu, input logic [63:0] mem,
                             input logic [63:0] pc4, input logic [63:0] pct,
                             input logic [63:0] imm);
        lane[SRC_ALU] = alu;
        lane[SRC_MEM] = mem;
        lane[SRC_PC4] = pc4;
        lane[SRC_PCT] = pct;
        lane[SRC_IMM] = imm;
        i_src_data = {imm, pct, pc4, mem, alu};
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [4:0] rd,
                         input logic we, input logic ecall);
        i_valid       = v;
        i_result_src  = sel;
        i_rd_addr     = rd;
        i_reg_we      = we;
        i_ecall_instr = ecall;
    endtask

    task automatic test_reset();
        i_arstn = 1'b0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        i_cause = '0;
        i_a0_reg_lsb = '0;
        set_lanes(64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (o_accept !== 1'b1) begin errors++; $display("FAIL reset_accept got %b exp 1", o_accept); end
        checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", o_halt); end
        checks++; if (o_retire !== 1'b0 || o_reg_we !== 1'b0) begin errors++; $display("FAIL reset_retire_we got %b/%b exp 0/0", o_retire, o_reg_we); end
        checks++; if (o_instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", o_instret); end
        checks++; if (o_result !== 64'd0 || o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_result got %h/%0d exp 0/0", o_result, o_rd_addr); end
        checks++; if (o_exit_a0 !== 8'd0 || o_exit_cause !== 4'd0) begin errors++; $display("FAIL reset_exit got %h/%0d exp 0/0", o_exit_a0, o_exit_cause); end
        i_arstn = 1'b1;
    endtask

    task automatic test_basic();
        set_lanes(64'h1234, 64'hBAD1, 64'hBAD2, 64'hBAD3, 64'hBAD4);
        drive(1'b1, 3'd0, 5'd5, 1'b1, 1'b0);
        tick();
        checks++; if (o_result !== 64'h1234) begin errors++; $display("FAIL basic_result got %h exp 1234", o_result); end
        checks++; if (o_rd_addr !== 5'd5) begin errors++; $display("FAIL basic_rd got %0d exp 5", o_rd_addr); end
        checks++; if (o_reg_we !== 1'b1 || o_retire !== 1'b1) begin errors++; $display("FAIL basic_we_retire got %b/%b exp 1/1", o_reg_we, o_retire); end
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (o_instret !== 64'd1) begin errors++; $display("FAIL basic_instret got %0d exp 1", o_instret); end
        checks++; if (o_retire !== 1'b0) begin errors++; $display("FAIL basic_idle_retire got %b exp 0", o_retire); end
    endtask

    task automatic test_back_to_back();
        bit         v_in  [7] = '{1, 1, 1, 1, 1, 1, 0};
        bit         st_in [7] = '{0, 1, 1, 0, 0, 0, 0};
        bit [2:0]   sel   [7] = '{0, 4, 4, 4, 2, 3, 0};
        bit [4:0]   rd    [7] = '{1, 2, 2, 2, 3, 4, 0};
        bit         e_ret [7] = '{1, 0, 0, 1, 1, 1, 0};
        int         retires = 0;
        int         bubbles = 0;
        set_lanes(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
        for (int c = 0; c < 7; c++) begin
            drive(v_in[c], sel[c], rd[c], 1'b1, 1'b0);
            i_stall = st_in[c];
            tick();
            checks++; if (o_retire !== e_ret[c] || o_reg_we !== e_ret[c]) begin errors++; $display("FAIL b2b_cycle%0d retire/we got %b/%b exp %b", c, o_retire, o_reg_we, e_ret[c]); end
            if (e_ret[c]) begin
                checks++; if (o_result !== lane[sel[c]] || o_rd_addr !== rd[c]) begin errors++; $display("FAIL b2b_data%0d got %h/%0d exp %h/%0d", c, o_result, o_rd_addr, lane[sel[c]], rd[c]); end
            end
            if (o_retire === 1'b1) retires++;
            if (c >= 1 && c <= 2 && o_reg_we === 1'b0) bubbles++;
        end
        i_stall = 1'b0;
        checks++; if (retires != 4) begin errors++; $display("FAIL b2b_retire_count got %0d exp 4", retires); end
        checks++; if (bubbles != 2) begin errors++; $display("FAIL b2b_bubbles got %0d exp 2", bubbles); end
        checks++; if (o_instret !== 64'd5) begin errors++; $display("FAIL b2b_instret got %0d exp 5", o_instret); end
    endtask

    task automatic test_x0_and_sel();
        set_lanes(64'hC0, 64'hDEAD, 64'hC2, 64'hC3, 64'hC4);
        drive(1'b1, 3'd1, 5'd0, 1'b1, 1'b0);
        tick();
        checks++; if (o_reg_we !== 1'b0 || o_retire !== 1'b1) begin errors++; $display("FAIL x0_we_retire got %b/%b exp 0/1", o_reg_we, o_retire); end
        checks++; if (o_result !== 64'hDEAD) begin errors++; $display("FAIL x0_load_result got %h exp dead", o_result); end
        drive(1'b1, 3'd7, 5'd3, 1'b1, 1'b0);
        tick();
        checks++; if (o_result !== 64'd0) begin errors++; $display("FAIL sel7_result got %h exp 0", o_result); end
        checks++; if (o_reg_we !== 1'b1) begin errors++; $display("FAIL sel7_we got %b exp 1", o_reg_we); end
        drive(1'b1, 3'd5, 5'd3, 1'b1, 1'b0);
        tick();
        checks++; if (o_result !== 64'd0) begin errors++; $display("FAIL sel5_result got %h exp 0", o_result); end
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (o_instret !== 64'd8) begin errors++; $display("FAIL x0_instret got %0d exp 8", o_instret); end
    endtask

    task automatic test_flush_ecall();
        i_cause = 4'd11;
        i_a0_reg_lsb = 8'h3C;
        drive(1'b1, 3'd0, 5'd10, 1'b0, 1'b1);
        i_flush = 1'b1;
        tick();
        checks++; if (o_retire !== 1'b0 || o_halt !== 1'b0) begin errors++; $display("FAIL flush_retire_halt got %b/%b exp 0/0", o_retire, o_halt); end
        i_flush = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (o_halt !== 1'b0 || o_accept !== 1'b1) begin errors++; $display("FAIL flush_state got halt %b accept %b exp 0/1", o_halt, o_accept); end
        checks++; if (o_instret !== 64'd8 || o_exit_cause !== 4'd0) begin errors++; $display("FAIL flush_instret_cause got %0d/%0d exp 8/0", o_instret, o_exit_cause); end
    endtask

    task automatic test_ecall_halt();
        set_lanes(64'hE0, 64'hE1, 64'hE2, 64'hE3, 64'hE4);
        i_cause = 4'd11;
        i_a0_reg_lsb = ECALL_PASS_A0;
        drive(1'b1, 3'd0, 5'd10, 1'b1, 1'b1);
        tick();
        checks++; if (o_retire !== 1'b1 || o_reg_we !== 1'b0) begin errors++; $display("FAIL ecall_retire_we got %b/%b exp 1/0", o_retire, o_reg_we); end
        checks++; if (o_halt !== 1'b0 || o_accept !== 1'b1) begin errors++; $display("FAIL ecall_pre_halt got %b/%b exp 0/1", o_halt, o_accept); end
        i_cause = 4'd3;
        i_a0_reg_lsb = 8'h55;
        drive(1'b1, 3'd0, 5'd6, 1'b1, 1'b0);
        tick();
        checks++; if (o_halt !== 1'b1 || o_accept !== 1'b0) begin errors++; $display("FAIL halt_state got %b/%b exp 1/0", o_halt, o_accept); end
        checks++; if (o_exit_a0 !== 8'h00 || o_exit_cause !== 4'd11) begin errors++; $display("FAIL halt_exit got %h/%0d exp 00/11", o_exit_a0, o_exit_cause); end
        checks++; if (o_retire !== 1'b0 || o_reg_we !== 1'b0) begin errors++; $display("FAIL halt_follow got %b/%b exp 0/0", o_retire, o_reg_we); end
        checks++; if (o_instret !== 64'd9) begin errors++; $display("FAIL halt_instret got %0d exp 9", o_instret); end
        i_cause = 4'd5;
        i_a0_reg_lsb = 8'h77;
        drive(1'b1, 3'd0, 5'd6, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (o_retire !== 1'b0 || o_instret !== 64'd9 || o_halt !== 1'b1) begin errors++; $display("FAIL halted_frozen%0d got retire %b instret %0d halt %b exp 0/9/1", c, o_retire, o_instret, o_halt); end
        end
        checks++; if (o_exit_a0 !== 8'h00 || o_exit_cause !== 4'd11) begin errors++; $display("FAIL halted_exit_hold got %h/%0d exp 00/11", o_exit_a0, o_exit_cause); end
    endtask

    task automatic test_reset_mid();
        #2;
        i_arstn = 1'b0;
        #1;
        checks++; if (o_halt !== 1'b0 || o_accept !== 1'b1) begin errors++; $display("FAIL arst_state got %b/%b exp 0/1", o_halt, o_accept); end
        checks++; if (o_instret !== 64'd0 || o_retire !== 1'b0) begin errors++; $display("FAIL arst_count got %0d/%b exp 0/0", o_instret, o_retire); end
        checks++; if (o_exit_cause !== 4'd0) begin errors++; $display("FAIL arst_exit got %0d exp 0", o_exit_cause); end
        @(negedge i_clk);
        i_cause = 4'd0;
        i_a0_reg_lsb = 8'h00;
        set_lanes(64'h7777, 64'hF1, 64'hF2, 64'hF3, 64'hF4);
        drive(1'b1, 3'd0, 5'd7, 1'b1, 1'b0);
        i_arstn = 1'b1;
        tick();
        checks++; if (o_retire !== 1'b1 || o_reg_we !== 1'b1 || o_result !== 64'h7777) begin errors++; $display("FAIL resume_first got %b/%b/%h exp 1/1/7777", o_retire, o_reg_we, o_result); end
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (o_instret !== 64'd1) begin errors++; $display("FAIL resume_instret got %0d exp 1", o_instret); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_x0_and_sel();
        test_flush_ecall();
        test_ecall_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
